// File: rtl/fwft_fifo.sv
// fwft_fifo: single-clock first-word-fall-through FIFO (accelerator instruction queue).
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   w_en, w_data           push request and data (dropped while full)
//   r_en, r_data           pop request; r_data shows the head entry while !empty
//   full, empty, count     registered occupancy status
//   flush                  synchronous clear of contents (sticky flags kept)
//   overflow, underflow    sticky error flags, cleared by err_clr
//   err_clr                synchronous clear of the sticky flags
//   max_level              peak occupancy (only with FWFT_FIFO_HIGH_WATERMARK_EN)
//
// Optional feature macro: FWFT_FIFO_HIGH_WATERMARK_EN adds the max_level watermark.
module fwft_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 5
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             w_en,
    input  logic [WIDTH-1:0] w_data,
    input  logic             r_en,
    output logic [WIDTH-1:0] r_data,
    output logic             full,
    output logic             empty,
    output logic [DEPTH:0]   count,
    input  logic             flush,
    output logic             overflow,
    output logic             underflow,
`ifdef FWFT_FIFO_HIGH_WATERMARK_EN
    output logic [DEPTH:0]   max_level,
`endif
    input  logic             err_clr
);

    localparam int unsigned PTR_W = DEPTH;
    localparam int unsigned CNT_W = DEPTH + 1;
    localparam int unsigned CAP   = 1 << DEPTH;

    logic [WIDTH-1:0] mem [CAP];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic push_ok;
    logic pop_ok;

    // Acceptance uses the registered flags, i.e. the state before the edge.
    assign push_ok = w_en && !full_q;
    assign pop_ok  = r_en && !empty_q;

    // Next-state pointers, occupancy, status and sticky flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        full_d      = (count_d == CNT_W'(CAP));
        empty_d     = (count_d == '0);
        // Set beats clear when both happen in the same cycle.
        overflow_d  = (w_en && full_q)  || (overflow_q  && !err_clr);
        underflow_d = (r_en && empty_q) || (underflow_q && !err_clr);
    end

    // Control state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; a flushed push must not land in memory.
    always_ff @(posedge aclk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_q] <= w_data;
        end
    end

    assign r_data    = mem[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef FWFT_FIFO_HIGH_WATERMARK_EN
    logic [CNT_W-1:0] max_level_q, max_level_d;

    // Peak tracker: follows the registered count one cycle late; err_clr rebases it.
    always_comb begin
        max_level_d = max_level_q;
        if (err_clr) begin
            max_level_d = count_q;
        end else if (count_q > max_level_q) begin
            max_level_d = count_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            max_level_q <= '0;
        end else begin
            max_level_q <= max_level_d;
        end
    end

    assign max_level = max_level_q;
`endif

endmodule

// File: tb/tb_fwft_fifo.sv
// tb_fwft_fifo: scoreboard bench for fwft_fifo with a queue-based reference model.
module tb_fwft_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned CAP   = 1 << DEPTH;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             w_en, r_en, flush, err_clr;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] r_data;
    logic             full, empty, overflow, underflow;
    logic [DEPTH:0]   count;
`ifdef FWFT_FIFO_HIGH_WATERMARK_EN
    logic [DEPTH:0]   max_level;
`endif

    fwft_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .w_en      (w_en),
        .w_data    (w_data),
        .r_en      (r_en),
        .r_data    (r_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .flush     (flush),
        .overflow  (overflow),
        .underflow (underflow),
`ifdef FWFT_FIFO_HIGH_WATERMARK_EN
        .max_level (max_level),
`endif
        .err_clr   (err_clr)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents as a queue plus flags; exp_q is the pop scoreboard.
    logic [WIDTH-1:0] mdl[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               m_ovf, m_unf;
    int unsigned      m_max;
    bit               mon_en = 1'b0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on each DUT pop.
    always @(negedge aclk) begin
        if (mon_en) begin
            chk("count", WIDTH'(count), WIDTH'(mdl.size()));
            chk("empty", WIDTH'(empty), WIDTH'(mdl.size() == 0));
            chk("full", WIDTH'(full), WIDTH'(mdl.size() == CAP));
            chk("overflow", WIDTH'(overflow), WIDTH'(m_ovf));
            chk("underflow", WIDTH'(underflow), WIDTH'(m_unf));
`ifdef FWFT_FIFO_HIGH_WATERMARK_EN
            chk("max_level", WIDTH'(max_level), WIDTH'(m_max));
`endif
            if (mdl.size() > 0) begin
                chk("r_data_head", r_data, mdl[0]);
            end
            if (r_en && !empty && !flush) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pop_unexpected: got %h, expected no pop", r_data);
                end else begin
                    chk("pop_data", r_data, exp_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; the model advances at the same edge as the DUT.
    task automatic step(input bit we, input logic [WIDTH-1:0] wd, input bit re,
                        input bit fl, input bit ec);
        int unsigned pre;
        bit          push_ok, pop_ok;
        w_en    = we;
        w_data  = wd;
        r_en    = re;
        flush   = fl;
        err_clr = ec;
        pre     = mdl.size();
        push_ok = we && (pre < CAP);
        pop_ok  = re && (pre > 0);
        if (fl) begin
            exp_q.delete();
        end else if (push_ok) begin
            exp_q.push_back(wd);
        end
        @(posedge aclk);
        m_ovf = (we && pre == CAP) || (m_ovf && !ec);
        m_unf = (re && pre == 0) || (m_unf && !ec);
        if (ec || pre > m_max) begin
            m_max = pre;
        end
        if (fl) begin
            mdl.delete();
        end else begin
            if (pop_ok) void'(mdl.pop_front());
            if (push_ok) mdl.push_back(wd);
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        mdl.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_max = 0;
    endtask

    initial begin
        aresetn = 1'b0;
        w_en    = 1'b0;
        w_data  = '0;
        r_en    = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        mon_en = 1'b1;
        idle();

        // First-word latency.
        step(1'b1, 32'hA000_0008, 1'b0, 1'b0, 1'b0);
        idle();
        chk("first_word", r_data, 32'hA000_0008);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Fill to capacity, overflow, drain in order.
        for (int i = 0; i < CAP; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        idle();
        chk("ovf_after_33", WIDTH'(overflow), WIDTH'(1));
        step(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < CAP; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Steady push+pop at count=1 with pointer wrap.
        step(1'b1, 32'h5555_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Underflow, clear, clear colliding with a new underflow.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle();
        step(1'b1, 32'hCAFE_0001, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush with a coincident push.
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBAD0_0000, 1'b0, 1'b1, 1'b0);
        idle();
        step(1'b1, 32'h0000_F00D, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

`ifdef FWFT_FIFO_HIGH_WATERMARK_EN
        // Watermark: push 7, pop 5, push 2, then rebase.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        idle();
        chk("max_level_peak", WIDTH'(max_level), WIDTH'(7));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("max_level_rebase", WIDTH'(max_level), WIDTH'(4));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
        end

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
        #2;
        mon_en  = 1'b0;
        aresetn = 1'b0;
        w_en    = 1'b0;
        #1;
        chk("async_rst_empty", WIDTH'(empty), WIDTH'(1));
        chk("async_rst_count", WIDTH'(count), WIDTH'(0));
        chk("async_rst_full", WIDTH'(full), WIDTH'(0));
        model_reset();
        @(posedge aclk);
        #1 aresetn = 1'b1;
        mon_en = 1'b1;
        idle();
        step(1'b1, 32'h0BAD_CAFE, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fwft_fifo.md
Name: fwft_fifo

Overview:
- Synchronous single-clock FIFO with first-word-fall-through (FWFT) read data.
- The head entry is presented on r_data while not empty, so consumers can decode it before popping.
- Used as the accelerator's instruction queue, between the AXI-Lite BRAM-style write path and the instruction decoder.
- Provides an occupancy count, a synchronous flush and sticky error flags.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 5, log2 of the entry count; capacity is 2**DEPTH (default 32 entries).

Ports:
- aclk  input  1  clock; all state updates on its rising edge.
- aresetn  input  1  asynchronous active-low reset.
- w_en  input  1  push request.
- w_data  input  WIDTH  push data.
- r_en  input  1  pop request.
- r_data  output  WIDTH  head entry (FWFT).
- full  output  1  FIFO holds 2**DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  DEPTH+1  current occupancy, 0..2**DEPTH.
- flush  input  1  synchronous clear of contents.
- overflow  output  1  sticky; a push was attempted while full.
- underflow  output  1  sticky; a pop was attempted while empty.
- err_clr  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (asynchronous, aresetn low):
  - Read/write pointers and count go to 0; empty=1, full=0, overflow=0, underflow=0.
  - Storage array is not reset. Reset mid-operation discards all contents.
- Storage: 2**DEPTH x WIDTH array, pointers DEPTH bits wide, wrapping modulo 2**DEPTH.
- Push accepted iff w_en && !full:
  - w_data is written at the write pointer and the write pointer increments.
- Pop accepted iff r_en && !empty:
  - Read pointer increments; the next entry appears on r_data in the following cycle.
- r_data = mem[rd_ptr], driven combinationally from the registered pointer.
  - Valid only while empty=0; value is undefined when empty.
- Latency: a word pushed into an empty FIFO appears on r_data, with empty=0, in the cycle after the push edge. There is no same-cycle bypass.
- full, empty and count are registered and derived from the next-state count.
  - count increments on an accepted push alone, decrements on an accepted pop alone, and is unchanged when both are accepted.
- Simultaneous push and pop:
  - When 0<count<2**DEPTH, both proceed and count is unchanged.
  - When full, the pop proceeds and the push is rejected (full is sampled before the edge), then overflow is set.
  - When empty, the push proceeds and the pop is rejected, then underflow is set.
- Rejected operations never modify storage or pointers.
- flush=1 at an edge: pointers and count go to 0, empty=1, full=0; any same-cycle push or pop is ignored. Sticky flags are unaffected.
- overflow sets on w_en && full; underflow sets on r_en && empty. Both hold until err_clr or reset.
  - If a set condition and err_clr occur in the same cycle, set wins.
- Flushing takes precedence over both push and pop.

Optional Feature:
- Macro FWFT_FIFO_HIGH_WATERMARK_EN.
- When defined:
  - Adds output max_level (DEPTH+1 bits, reset 0) holding the peak count since reset or the last err_clr.
  - max_level updates the cycle after count exceeds it.
  - err_clr loads max_level with the current count.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then push 0xA0000008 (WIDTH=32, DEPTH=5) -> empty=1 during the push cycle; next cycle empty=0, r_data=0xA0000008, count=1.
- Push 32 words 0..31 with no pops -> full=1, count=32. A 33rd push is dropped and overflow=1. Popping 32 times returns 0..31 in order, then empty=1.
- Simultaneous push and pop at count=1 for 100 cycles -> count stays 1 and r_data tracks each pushed word one cycle late, in order. Pointers wrap past 31 without data loss.
- Pop while empty -> underflow=1, pointers unchanged. err_clr -> underflow=0 the next cycle. err_clr coinciding with a new underflow -> underflow stays 1.
- Fill with 10 words, assert flush together with w_en -> count=0, empty=1, pushed word discarded. Deassert aresetn mid-stream -> immediate empty=1, count=0, without waiting for a clock edge.
- With FWFT_FIFO_HIGH_WATERMARK_EN defined, push 7, pop 5, push 2 -> max_level=7. err_clr -> max_level=4.
